id_ex_stage_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.

---
 rtl/id_ex_stage_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// flush squashing and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              RegWriteID,
  input  logic              MemReadID,
  input  logic              MemWriteID,
  input  logic              MemToRegID,
  input  logic              ALUSrcID,
  input  logic              RegDstID,
  input  logic [2:0]        ALUOpID,
  input  logic [DATA_W-1:0] ReadData1ID,
  input  logic [DATA_W-1:0] ReadData2ID,
  input  logic [DATA_W-1:0] ImmID,
  input  logic [4:0]        RsIFID,
  input  logic [4:0]        RtIFID,
  input  logic [4:0]        RdIFID,
  output logic              stall,
  output logic              RegWriteIDEX,
  output logic              MemReadIDEX,
  output logic              MemWriteIDEX,
  output logic              MemToRegIDEX,
  output logic              ALUSrcIDEX,
  output logic              RegDstIDEX,
  output logic [2:0]        ALUOpIDEX,
  output logic [DATA_W-1:0] ReadData1IDEX,
  output logic [DATA_W-1:0] ReadData2IDEX,
  output logic [DATA_W-1:0] ImmIDEX,
  output logic [4:0]        RsIDEX,
  output logic [4:0]        RtIDEX,
  output logic [4:0]        RdIDEX,
  output logic [4:0]        DestIDEX,
  output logic              ValidIDEX,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic       rw;
    logic       mr;
    logic       mw;
    logic       mtr;
    logic       src;
    logic       rdst;
    logic [2:0] op;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  ctrl_t             w_ctrl_in;
  logic              w_stall;
  logic              w_bubble;

  assign w_ctrl_in = '{
    rw:   RegWriteID,
    mr:   MemReadID,
    mw:   MemWriteID,
    mtr:  MemToRegID,
    src:  ALUSrcID,
    rdst: RegDstID,
    op:   ALUOpID
  };

  // Only a real load in EX with a nonzero target can hazard.
  assign w_stall = r_valid & r_ctrl.mr & (r_rt != 5'd0) &
                   ((r_rt == RsIFID) | (r_rt == RtIFID));

  assign w_bubble = flush | w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_d1  <= ReadData1ID;
      r_d2  <= ReadData2ID;
      r_imm <= ImmID;
      r_rs  <= RsIFID;
      r_rt  <= RtIFID;
      r_rd  <= RdIFID;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
        if (r_cnt != CNT_MAX)
          r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_ctrl  <= w_ctrl_in;
        r_valid <= 1'b1;
      end
    end
  end

  assign stall         = w_stall;
  assign RegWriteIDEX  = r_ctrl.rw;
  assign MemReadIDEX   = r_ctrl.mr;
  assign MemWriteIDEX  = r_ctrl.mw;
  assign MemToRegIDEX  = r_ctrl.mtr;
  assign ALUSrcIDEX    = r_ctrl.src;
  assign RegDstIDEX    = r_ctrl.rdst;
  assign ALUOpIDEX     = r_ctrl.op;
  assign ReadData1IDEX = r_d1;
  assign ReadData2IDEX = r_d2;
  assign ImmIDEX       = r_imm;
  assign RsIDEX        = r_rs;
  assign RtIDEX        = r_rt;
  assign RdIDEX        = r_rd;
  assign DestIDEX      = r_ctrl.rdst ? r_rd : r_rt;
  assign ValidIDEX     = r_valid;
  assign bubble_cnt    = r_cnt;

endmodule
